// File: rtl/johnson_phase_decoder.sv
// rtl/johnson_phase_decoder.sv - Johnson state to phase decoder with sequence checking and lap/error counters (option: JOHNSON_PHASE_DEC_ERRCNT_EN)
module johnson_phase_decoder #(
  parameter int WIDTH = 4,
  parameter int PW    = $clog2(2 * WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [0:WIDTH-1]   q_in,
  input  logic               in_valid,
  output logic [PW-1:0]      phase,
  output logic [2*WIDTH-1:0] phase_onehot,
  output logic               phase_valid,
  output logic               wrap,
  output logic               seq_err,
  output logic               err_sticky,
  output logic [7:0]         err_count,
  output logic [7:0]         lap_count
);

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t        state;
  logic          dec_legal;
  logic [PW-1:0] dec_phase;
  logic [PW-1:0] exp_phase;
  logic          exp_match;
  logic          err_evt;
  logic          wrap_evt;

  // Pattern with the first k bits (from q_in[0]) set and the rest clear.
  function automatic logic [0:WIDTH-1] lead_ones(input int k);
    logic [0:WIDTH-1] p;
    p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      p[i] = (i < k);
    end
    return p;
  endfunction

  function automatic logic [2*WIDTH-1:0] onehot_of(input logic [PW-1:0] p);
    logic [2*WIDTH-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Decode the incoming sample: leading-ones runs are phases 0..W-1, leading-zeros runs are W..2W-1.
  always_comb begin
    dec_legal = 1'b0;
    dec_phase = '0;
    for (int k = 1; k <= WIDTH; k++) begin
      if (q_in == lead_ones(k)) begin
        dec_legal = 1'b1;
        dec_phase = PW'(k - 1);
      end
      if (q_in == ~lead_ones(k)) begin
        dec_legal = 1'b1;
        dec_phase = PW'(WIDTH + k - 1);
      end
    end
  end

  // Successor check against the locked phase; an illegal pattern is always a fault, a legal one only when tracking.
  always_comb begin
    exp_phase = (phase == PW'(2 * WIDTH - 1)) ? '0 : phase + PW'(1);
    exp_match = dec_legal && (dec_phase == exp_phase);
    err_evt   = in_valid && (!dec_legal || (state == TRACK && !exp_match));
    wrap_evt  = in_valid && (state == TRACK) && exp_match && (exp_phase == '0);
  end

  // Lock state machine with registered phase outputs, event pulses and lap counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HUNT;
      phase        <= '0;
      phase_onehot <= '0;
      phase_valid  <= 1'b0;
      wrap         <= 1'b0;
      seq_err      <= 1'b0;
      err_sticky   <= 1'b0;
      lap_count    <= 8'd0;
    end else begin
      wrap    <= wrap_evt;
      seq_err <= err_evt;
      if (err_evt) begin
        err_sticky <= 1'b1;
      end
      if (wrap_evt) begin
        lap_count <= lap_count + 8'd1;
      end
      if (in_valid) begin
        if (dec_legal) begin
          // Fresh lock, expected successor or relock all load the decoded phase.
          state        <= TRACK;
          phase        <= dec_phase;
          phase_onehot <= onehot_of(dec_phase);
          phase_valid  <= 1'b1;
        end else begin
          // Lose lock; phase keeps its last value for observation.
          state        <= HUNT;
          phase_onehot <= '0;
          phase_valid  <= 1'b0;
        end
      end
    end
  end

`ifdef JOHNSON_PHASE_DEC_ERRCNT_EN
  // Fault counter, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if (err_evt && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: doc/johnson_phase_decoder.md
# johnson_phase_decoder

Registered decoder and sequence checker placed directly downstream of the 4-bit ring/Johnson counter. It converts each Johnson state into a binary phase index and a one-hot phase select, and confirms that every new state is the legal successor of the previous one. Sequence faults are flagged and counted, and completed laps are counted. Downstream phase-select logic consumes the decoded outputs; upstream counter health is read from the error outputs.

## Interface
- `WIDTH`, default 4: Johnson register width; the sequence has 2*WIDTH states.
- `PW`, default $clog2(2*WIDTH): width of the phase index.
- `clk` in 1: the single clock; all activity occurs on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `q_in` in [0:WIDTH-1]: Johnson state; `q_in[0]` is the bit the counter shifts in.
- `in_valid` in 1: `q_in` is a new sample this cycle. Tie high when the counter advances every clock.
- `phase` out PW: decoded phase index.
- `phase_onehot` out 2*WIDTH: one-hot select, with bit `phase` set while locked.
- `phase_valid` out 1: high while in TRACK.
- `wrap` out 1: one-cycle pulse on a legal 2*WIDTH-1 -> 0 transition.
- `seq_err` out 1: one-cycle pulse on any sequence fault.
- `err_sticky` out 1: set on the first fault; cleared only by `rst`.
- `err_count` out 8: count of faults, saturating at 255.
- `lap_count` out 8: count of wraps, modulo 256.

## Operation
- Legal state decode:
  - k leading ones from `q_in[0]` and zeros after, k = 1..WIDTH, gives phase k-1.
  - k leading zeros from `q_in[0]` and ones after, k = 1..WIDTH, gives phase WIDTH+k-1.
  - Any other pattern is illegal.
- For WIDTH=4 the phases are: 1000=0, 1100=1, 1110=2, 1111=3, 0111=4, 0011=5, 0001=6, 0000=7.
- There are two states, HUNT and TRACK.
- HUNT:
  - Entered at reset.
  - `phase_valid` is 0 and `phase_onehot` is 0.
  - A valid legal sample loads `phase` and moves to TRACK, with no `seq_err`.
  - A valid illegal sample pulses `seq_err` and remains in HUNT.
- TRACK:
  - The expected phase is (`phase`+1) mod 2*WIDTH.
  - A valid sample equal to the expected phase updates `phase`. If the expected phase is 0, `wrap` pulses and `lap_count` increments.
  - A valid legal sample that is not the expected phase (a skip, a repeat or a reversal) pulses `seq_err` and relocks to the new phase, staying in TRACK. No `wrap` is produced on a relock.
  - A valid illegal sample pulses `seq_err`, moves to HUNT and clears `phase_valid` and `phase_onehot`. `phase` holds its last value.
- Any `seq_err` pulse sets `err_sticky` and increments `err_count`, which saturates at 255.
- When `in_valid` is 0, all state holds and `wrap` and `seq_err` are 0.
- `lap_count` wraps from 255 to 0 silently.

## Timing
- All outputs are registered with a latency of 1 cycle: a sample presented at edge N is reflected after edge N+1.
- Reset values (`rst` high at an edge):
  - `phase` = 0, `phase_onehot` = 0, `phase_valid` = 0.
  - `wrap` = 0, `seq_err` = 0, `err_sticky` = 0.
  - `err_count` = 0, `lap_count` = 0.
  - State = HUNT.
- Reset has priority over `in_valid`.
- Reset mid-lap discards lock. The upstream counter's reset state (1000) is then accepted as a fresh lock, with no error.
- Reset behaviour when the counter and decoder share `rst`:
  - While `rst` is held, samples are ignored.
  - The first valid sample after `rst` deasserts is treated as a HUNT sample.
- `wrap` and `seq_err` are never both high in the same cycle.
- `phase_onehot` always equals the decode of `phase` when `phase_valid` is 1, and is 0 otherwise.

## Configuration
- Macro: `JOHNSON_PHASE_DEC_ERRCNT_EN`.
- Defined: the `err_count` register and saturating increment are built as described above.
- Undefined: `err_count` is tied to 8'd0 and no counter logic is synthesised. `seq_err` and `err_sticky` are unchanged.

## Test plan
- Reset, then apply 1000,1100,1110,1111,0111,0011,0001,0000,1000 with `in_valid`=1 -> `phase` 0..7 then 0. `phase_valid` rises one cycle after the first sample. `wrap` pulses once and `lap_count`=1. `seq_err` never fires.
- In TRACK at phase 2, apply 0111 (phase 4, a skip) -> `seq_err` pulses, `phase`=4, `phase_valid` stays 1, `err_sticky`=1, `err_count`=1.
- In TRACK, apply 1010 -> `seq_err` pulses, HUNT, `phase_valid`=0, `phase_onehot`=0. Then apply 0011 -> relock at phase 5 with no new error.
- Toggle `in_valid` low for 3 cycles mid-sequence while `q_in` changes -> outputs hold. On resume the next expected state is accepted with no error.
- Inject 260 illegal samples -> `err_count` saturates at 255. With the macro undefined, it stays at 0 throughout.
- Assert `rst` at phase 5 with `err_sticky`=1 -> all outputs return to their reset values. A following 1000 relocks at phase 0 with no error.
